// File: rtl/vga_pkg.sv
// ============================================================================
// Module : vga_pkg
// Brief  : Shared VGA constants, pattern-mode enum and RGB565 colours.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package vga_pkg;

  localparam int H_ACT = 640;
  localparam int V_ACT = 480;

  typedef enum logic [1:0] {
    MODE_RED   = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_BOX   = 2'd3
  } mode_e;

  localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
  localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
  localparam logic [15:0] RGB_CYAN    = 16'h07FF;
  localparam logic [15:0] RGB_GREEN   = 16'h07E0;
  localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
  localparam logic [15:0] RGB_RED     = 16'hF800;
  localparam logic [15:0] RGB_BLUE    = 16'h001F;
  localparam logic [15:0] RGB_BLACK   = 16'h0000;

  function automatic logic [15:0] bar_colour(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = RGB_WHITE;
      3'd1:    c = RGB_YELLOW;
      3'd2:    c = RGB_CYAN;
      3'd3:    c = RGB_GREEN;
      3'd4:    c = RGB_MAGENTA;
      3'd5:    c = RGB_RED;
      3'd6:    c = RGB_BLUE;
      default: c = RGB_BLACK;
    endcase
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_pixel_src_key_debounce.sv
// ============================================================================
// Module : key_debounce
// Brief  : 2-flop synchroniser, stable-time debouncer and press pulse for an
//          active-low pushbutton.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module key_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n_i,
  output logic press_o
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic          sync1_q;
  logic          sync2_q;
  logic          deb_q;
  logic          press_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      deb_q   <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      // Counting runs only while the synchronised level disagrees.
      if (sync2_q == deb_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        deb_q   <= sync2_q;
        cnt_q   <= '0;
        press_q <= ~sync2_q;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign press_o = press_q;

endmodule

`default_nettype wire

// File: rtl/vga_pixel_src.sv
// ============================================================================
// Module : vga_pixel_src
// Brief  : RGB565 test-pattern source for the VGA timing block, one-cycle
//          latency. Define VGA_PIXEL_SRC_GRID_EN for a white grid overlay.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module vga_pixel_src
  import vga_pkg::*;
#(
  parameter int H_ACT      = vga_pkg::H_ACT,
  parameter int V_ACT      = vga_pkg::V_ACT,
  parameter int DEB_CYCLES = 500000,
  parameter int BOX_SIZE   = 32,
  parameter int CHK_SHIFT  = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_sync,
  input  logic        pix_req,
  input  logic        key_n,
  output logic [15:0] pix_rgb,
  output logic        pix_vld,
  output logic [1:0]  mode
);

  logic [9:0]  x_q;
  logic [8:0]  y_q;
  logic [9:0]  bx_q;
  logic [8:0]  by_q;
  logic        bdx_q;
  logic        bdy_q;
  mode_e       mode_q;
  mode_e       pend_q;
  logic [15:0] rgb_q;
  logic        vld_q;
  logic        press;
  logic [15:0] pix_d;
  logic [2:0]  bar_idx;
  logic [10:0] bx_end;
  logic [9:0]  by_end;
  logic        in_box;

  key_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_key (
    .clk    (clk),
    .rst_n  (rst_n),
    .key_n_i(key_n),
    .press_o(press)
  );

  assign bar_idx = 3'(x_q / 10'(H_ACT / 8));
  assign bx_end  = {1'b0, bx_q} + 11'(BOX_SIZE);
  assign by_end  = {1'b0, by_q} + 10'(BOX_SIZE);
  assign in_box  = (x_q >= bx_q) && ({1'b0, x_q} < bx_end) &&
                   (y_q >= by_q) && ({1'b0, y_q} < by_end);

  always_comb begin
    pix_d = RGB_BLACK;
    case (mode_q)
      MODE_RED:   pix_d = RGB_RED;
      MODE_BARS:  pix_d = bar_colour(bar_idx);
      MODE_CHECK: pix_d = (x_q[CHK_SHIFT] ^ y_q[CHK_SHIFT]) ? RGB_WHITE : RGB_BLACK;
      MODE_BOX:   pix_d = in_box ? RGB_GREEN : RGB_BLACK;
      default:    pix_d = RGB_BLACK;
    endcase
`ifdef VGA_PIXEL_SRC_GRID_EN
    if ((x_q[5:0] == 6'd0) || (y_q[5:0] == 6'd0)) pix_d = RGB_WHITE;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q    <= '0;
      y_q    <= '0;
      bx_q   <= '0;
      by_q   <= '0;
      bdx_q  <= 1'b1;
      bdy_q  <= 1'b1;
      mode_q <= MODE_RED;
      pend_q <= MODE_RED;
      rgb_q  <= '0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= pix_req;
      rgb_q <= pix_req ? pix_d : RGB_BLACK;

      if (press) pend_q <= mode_e'(pend_q + 2'd1);

      if (frame_sync) begin
        x_q    <= '0;
        y_q    <= '0;
        mode_q <= pend_q;
        // At a bound the box turns around and holds still for one frame.
        if (bdx_q) begin
          if (bx_q == 10'(H_ACT - BOX_SIZE)) bdx_q <= 1'b0;
          else                               bx_q  <= bx_q + 10'd1;
        end else begin
          if (bx_q == 10'd0) bdx_q <= 1'b1;
          else               bx_q  <= bx_q - 10'd1;
        end
        if (bdy_q) begin
          if (by_q == 9'(V_ACT - BOX_SIZE)) bdy_q <= 1'b0;
          else                              by_q  <= by_q + 9'd1;
        end else begin
          if (by_q == 9'd0) bdy_q <= 1'b1;
          else              by_q  <= by_q - 9'd1;
        end
      end else if (pix_req) begin
        if (x_q == 10'(H_ACT - 1)) begin
          x_q <= '0;
          y_q <= (y_q == 9'(V_ACT - 1)) ? 9'd0 : y_q + 9'd1;
        end else begin
          x_q <= x_q + 10'd1;
        end
      end
    end
  end

  assign pix_rgb = rgb_q;
  assign pix_vld = vld_q;
  assign mode    = mode_q;

endmodule

`default_nettype wire
